// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the two-write-port register file: round-robin grants onto
// ports C and D, same-address pairs split across cycles, freeze holds everything.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned LOG_REG_CNT       = 2,
    parameter int unsigned SUPERSCALAR_WIDTH = 4,
    parameter int unsigned REG_WIDTH         = 288,
    localparam int unsigned TW   = $clog2(SUPERSCALAR_WIDTH),
    localparam int unsigned AW   = LOG_REG_CNT * SUPERSCALAR_WIDTH,
    localparam int unsigned NREG = (1 << LOG_REG_CNT) * SUPERSCALAR_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           freeze,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TW-1:0]          req_thread,
    input  logic [NUM_REQ*LOG_REG_CNT-1:0] req_reg,
    input  logic [NUM_REQ*REG_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           port_c_we,
    output logic                           port_d_we,
    output logic [AW-1:0]                  port_c_write_addr,
    output logic [AW-1:0]                  port_d_write_addr,
    output logic [REG_WIDTH-1:0]           port_c_in,
    output logic [REG_WIDTH-1:0]           port_d_in,
    output logic [NREG-1:0]                pend_mask
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned LW = TW + LOG_REG_CNT;

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_next;
    logic [NUM_REQ-1:0] elig;
    logic [AW-1:0]      req_addr [NUM_REQ];

    logic               c_hit;
    logic               d_hit;
    logic [PW-1:0]      c_sel;
    logic [PW-1:0]      d_sel;
    logic [PW-1:0]      idx;
    logic [PW-1:0]      last;
    logic [PW:0]        sum;
    logic [NREG-1:0]    pend_next;

    // Reset gates eligibility so req_ready is low for the whole reset window.
    assign elig = req_valid & {NUM_REQ{reset & ~freeze}};

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_addr[i]         = '0;
            req_addr[i][LW-1:0] = {req_thread[i*TW +: TW], req_reg[i*LOG_REG_CNT +: LOG_REG_CNT]};
        end
    end

    always_comb begin
        c_hit     = 1'b0;
        d_hit     = 1'b0;
        c_sel     = '0;
        d_sel     = '0;
        idx       = '0;
        sum       = '0;
        last      = '0;
        req_ready = '0;
        rr_next   = rr_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            idx = sum[PW-1:0];
            if (elig[idx]) begin
                if (!c_hit) begin
                    c_hit = 1'b1;
                    c_sel = idx;
                end else if (!d_hit && (req_addr[idx] != req_addr[c_sel])) begin
                    d_hit = 1'b1;
                    d_sel = idx;
                end
            end
        end
        if (c_hit) req_ready[c_sel] = 1'b1;
        if (d_hit) req_ready[d_sel] = 1'b1;
        // D is always later in scan order than C, so it is the last grant when present.
        last = d_hit ? d_sel : c_sel;
        if (c_hit)
            rr_next = (last == PW'(NUM_REQ - 1)) ? '0 : last + PW'(1);
    end

    always_comb begin
        pend_next = '0;
        for (int unsigned a = 0; a < NREG; a++) begin
            pend_next[a] = (c_hit && (req_addr[c_sel] == AW'(a))) ||
                           (d_hit && (req_addr[d_sel] == AW'(a)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_c_we         <= 1'b0;
            port_d_we         <= 1'b0;
            port_c_write_addr <= '0;
            port_d_write_addr <= '0;
            port_c_in         <= '0;
            port_d_in         <= '0;
            pend_mask         <= '0;
            rr_ptr            <= '0;
        end else if (!freeze) begin
            port_c_we <= c_hit;
            port_d_we <= d_hit;
            if (c_hit) begin
                port_c_write_addr <= req_addr[c_sel];
                port_c_in         <= req_data[c_sel*REG_WIDTH +: REG_WIDTH];
            end
            if (d_hit) begin
                port_d_write_addr <= req_addr[d_sel];
                port_d_in         <= req_data[d_sel*REG_WIDTH +: REG_WIDTH];
            end
            pend_mask <= pend_next;
            rr_ptr    <= rr_next;
        end
    end

endmodule
